// File: rtl/demux_8x1_reg_n_if.sv
// ---------------------------------------------------------------------------
// demux_8x1_reg_n_if
//
// Bundles the write-side bus and the register-bank outputs of the
// demux_8x1_reg_n register-bank writer.
//
// Signals (BITS = data width):
//   D      [BITS-1:0]  data word to write
//   SEL    [2:0]       target register for addressed writes (MODE=0)
//   MODE               0 = addressed write, 1 = sequential write
//   WE                 write enable
//   CLEAR              synchronous clear of bank, valid flags and pointer
//   Q0..Q7 [BITS-1:0]  bank registers
//   VALID  [7:0]       per-register "written since reset/clear" flags
//   PTR    [2:0]       sequential write pointer
//   FULL               all eight VALID bits set
//   ERRO               one-cycle pulse after a rejected write
//
// Modports:
//   master - the writer side (drives D/SEL/MODE/WE/CLEAR)
//   slave  - the register bank (drives Q0..Q7/VALID/PTR/FULL/ERRO)
// ---------------------------------------------------------------------------
interface demux_8x1_reg_n_if #(
   parameter int BITS = 4
);
   logic [BITS-1:0] D;
   logic [2:0]      SEL;
   logic            MODE;
   logic            WE;
   logic            CLEAR;
   logic [BITS-1:0] Q0;
   logic [BITS-1:0] Q1;
   logic [BITS-1:0] Q2;
   logic [BITS-1:0] Q3;
   logic [BITS-1:0] Q4;
   logic [BITS-1:0] Q5;
   logic [BITS-1:0] Q6;
   logic [BITS-1:0] Q7;
   logic [7:0]      VALID;
   logic [2:0]      PTR;
   logic            FULL;
   logic            ERRO;

   modport master (
      output D, SEL, MODE, WE, CLEAR,
      input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, VALID, PTR, FULL, ERRO
   );

   modport slave (
      input  D, SEL, MODE, WE, CLEAR,
      output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, VALID, PTR, FULL, ERRO
   );
endinterface

// File: rtl/demux_8x1_reg_n.sv
// ---------------------------------------------------------------------------
// demux_8x1_reg_n
//
// Registered 1-to-8 demultiplexer / register-bank writer. A BITS-wide word
// is captured into one of eight registers, chosen either by SEL (MODE=0) or
// by an internal auto-incrementing pointer (MODE=1). A per-register valid
// flag records which slots hold fresh data for the downstream reader.
//
// Ports:
//   clock  - system clock, all state changes on the rising edge
//   reset  - synchronous, active-high reset (highest priority)
//   bus    - demux_8x1_reg_n_if.slave: D, SEL, MODE, WE, CLEAR in;
//            Q0..Q7, VALID, PTR, FULL, ERRO out
//
// Configuration macro:
//   DEMUX_WRITE_PROTECT_EN - when defined, a write to a register whose
//   VALID flag is already set is rejected: the register and pointer hold
//   and ERRO pulses for one cycle. When undefined, writes always overwrite
//   and ERRO stays 0.
// ---------------------------------------------------------------------------
module demux_8x1_reg_n #(
   parameter int BITS = 4
) (
   input logic                  clock,
   input logic                  reset,
   demux_8x1_reg_n_if.slave     bus
);

   logic [BITS-1:0] bank_q [8];
   logic [BITS-1:0] bank_d [8];
   logic [7:0]      valid_q;
   logic [7:0]      valid_d;
   logic [2:0]      ptr_q;
   logic [2:0]      ptr_d;
   logic            erro_q;
   logic            erro_d;

   logic [2:0]      writeTarget;
   logic            writeReject;

   // The target slot comes from the pointer in sequential mode and from SEL
   // otherwise; MODE is taken fresh on every edge.
   assign writeTarget = bus.MODE ? ptr_q : bus.SEL;

   // A write is only ever refused when protection is compiled in and the
   // target slot already holds unread data. Once every slot is valid this
   // refuses all further writes until a clear.
`ifdef DEMUX_WRITE_PROTECT_EN
   assign writeReject = bus.WE & ~bus.CLEAR & valid_q[writeTarget];
`else
   assign writeReject = 1'b0;
`endif

   // Next-state computation: CLEAR wipes everything and discards any write
   // in the same cycle; an accepted write touches only the target slot and
   // advances the pointer only in sequential mode.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         bank_d[i] = bank_q[i];
      end
      valid_d = valid_q;
      ptr_d   = ptr_q;
      erro_d  = writeReject;

      if (bus.CLEAR) begin
         for (int i = 0; i < 8; i++) begin
            bank_d[i] = '0;
         end
         valid_d = 8'h00;
         ptr_d   = 3'd0;
         erro_d  = 1'b0;
      end else if (bus.WE && !writeReject) begin
         bank_d[writeTarget]  = bus.D;
         valid_d[writeTarget] = 1'b1;
         if (bus.MODE) begin
            ptr_d = ptr_q + 3'd1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            bank_q[i] <= '0;
         end
         valid_q <= 8'h00;
         ptr_q   <= 3'd0;
         erro_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            bank_q[i] <= bank_d[i];
         end
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         erro_q  <= erro_d;
      end
   end

   assign bus.Q0    = bank_q[0];
   assign bus.Q1    = bank_q[1];
   assign bus.Q2    = bank_q[2];
   assign bus.Q3    = bank_q[3];
   assign bus.Q4    = bank_q[4];
   assign bus.Q5    = bank_q[5];
   assign bus.Q6    = bank_q[6];
   assign bus.Q7    = bank_q[7];
   assign bus.VALID = valid_q;
   assign bus.PTR   = ptr_q;
   assign bus.FULL  = &valid_q;
   assign bus.ERRO  = erro_q;

endmodule
